// File: rtl/tmr_clk_pkg.sv
// tmr_clk_pkg: clock-source decode types, prescaler tap indices and filter default for the timer count-enable generator
package tmr_clk_pkg;

   typedef enum logic [2:0] {
      SRC_OFF,
      SRC_INT,
      SRC_CASCADE,
      SRC_EXT_RISE,
      SRC_EXT_FALL,
      SRC_EXT_BOTH
   } cks_src_e;

   typedef enum logic [1:0] {
      EDGE_NONE,
      EDGE_RISE,
      EDGE_FALL,
      EDGE_BOTH
   } edge_e;

   // Prescaler bit carrying phi/2^k is bit k-1.
   localparam int TAP_DIV2    = 0;
   localparam int TAP_DIV8    = 2;
   localparam int TAP_DIV32   = 4;
   localparam int TAP_DIV64   = 5;
   localparam int TAP_DIV1024 = 9;
   localparam int TAP_DIV8192 = 12;

   localparam int FILT_LEN_DEF = 3;

   function automatic cks_src_e decode_src(input logic [2:0] cks);
      if (!cks[2]) return (cks[1:0] == 2'b00) ? SRC_OFF : SRC_INT;
      case (cks[1:0])
         2'b00:   return SRC_CASCADE;
         2'b01:   return SRC_EXT_RISE;
         2'b10:   return SRC_EXT_FALL;
         default: return SRC_EXT_BOTH;
      endcase
   endfunction

   // Internal tap code is {cks[1:0], icks[0]}; codes 000/001 select no tap.
   function automatic logic [3:0] tap_idx(input logic [2:0] code);
      case (code)
         3'b010:  return 4'(TAP_DIV8);
         3'b011:  return 4'(TAP_DIV2);
         3'b100:  return 4'(TAP_DIV64);
         3'b101:  return 4'(TAP_DIV32);
         3'b110:  return 4'(TAP_DIV8192);
         3'b111:  return 4'(TAP_DIV1024);
         default: return 4'(TAP_DIV2);
      endcase
   endfunction

   function automatic edge_e edge_of(input cks_src_e src, input logic falling);
      case (src)
         SRC_INT:      return falling ? EDGE_FALL : EDGE_RISE;
         SRC_CASCADE:  return EDGE_RISE;
         SRC_EXT_RISE: return EDGE_RISE;
         SRC_EXT_FALL: return EDGE_FALL;
         SRC_EXT_BOTH: return EDGE_BOTH;
         default:      return EDGE_NONE;
      endcase
   endfunction

endpackage

// File: rtl/tmr_edge_sel_ch.sv
// tmr_edge_sel_ch: one channel - TMCI synchroniser, optional TMCI filter (TMR_TMCI_FILTER_EN), source mux, edge history, select-change blanking, registered pulse
module tmr_edge_sel_ch
   import tmr_clk_pkg::*;
#(
   parameter int PRESC_W  = 13,
   parameter int SYNC_STG = 2,
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_presc_clr,
   input  logic [PRESC_W-1:0] i_presc,
   input  logic [2:0]         i_cks,
   input  logic [1:0]         i_icks,
   input  logic               i_tmci,
   input  logic               i_cascade,
   output logic               o_cnt_en
);

   if (SYNC_STG < 2 || FILT_LEN < 1) begin : g_bad_cfg
      $error("tmr_edge_sel_ch: SYNC_STG must be >= 2 and FILT_LEN >= 1");
   end

   logic [SYNC_STG-1:0] sync_q;
   logic                ext_lvl;
   logic [4:0]          sel_q;
   logic                hist_q, hist_d;
   logic                cnt_en_q, cnt_en_d;
   logic                lvl, rise, fall, hit;
   cks_src_e            src;
   edge_e               edg;

   // Shift the asynchronous TMCI level through the synchroniser chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STG-2:0], i_tmci};
   end

`ifdef TMR_TMCI_FILTER_EN
   localparam int FCW = $clog2(FILT_LEN + 1);
   logic           filt_q;
   logic [FCW-1:0] fcnt_q;

   // Accept a new TMCI level only after FILT_LEN consecutive samples disagree with the current one.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else if (sync_q[SYNC_STG-1] == filt_q) begin
         fcnt_q <= '0;
      end else if (fcnt_q == FCW'(FILT_LEN - 1)) begin
         filt_q <= sync_q[SYNC_STG-1];
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_q + 1'b1;
      end
   end

   assign ext_lvl = filt_q;
`else
   assign ext_lvl = sync_q[SYNC_STG-1];
`endif

   // Pick the source level, detect the configured edge and blank the cycle a new select appears.
   always_comb begin
      src      = decode_src(i_cks);
      edg      = edge_of(src, i_icks[1]);
      lvl      = (src == SRC_INT)     ? i_presc[tap_idx({i_cks[1:0], i_icks[0]})] :
                 (src == SRC_CASCADE) ? i_cascade :
                 (src == SRC_OFF)     ? 1'b0 : ext_lvl;
      rise     = lvl & ~hist_q;
      fall     = ~lvl & hist_q;
      hit      = (edg == EDGE_RISE) ? rise :
                 (edg == EDGE_FALL) ? fall :
                 (edg == EDGE_BOTH) ? (rise | fall) : 1'b0;
      cnt_en_d = hit && ({i_cks, i_icks} == sel_q);
      // A prescaler clear drives every tap to 0, so preload that to avoid a false edge.
      hist_d   = (i_presc_clr && src == SRC_INT) ? 1'b0 : lvl;
   end

   // Register stored select, edge history and the output pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sel_q    <= '0;
         hist_q   <= 1'b0;
         cnt_en_q <= 1'b0;
      end else begin
         sel_q    <= {i_cks, i_icks};
         hist_q   <= hist_d;
         cnt_en_q <= cnt_en_d;
      end
   end

   assign o_cnt_en = cnt_en_q;

endmodule

// File: rtl/tmr_cnt_en_gen.sv
// tmr_cnt_en_gen: shared prescaler plus NUM_CH count-enable channels for the APB timer; TMCI filter enabled by TMR_TMCI_FILTER_EN
module tmr_cnt_en_gen
   import tmr_clk_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int PRESC_W  = 13,
   parameter int SYNC_STG = 2,
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_presc_clr,
   input  logic [3*NUM_CH-1:0]   i_cks,
   input  logic [2*NUM_CH-1:0]   i_icks,
   input  logic [NUM_CH-1:0]     i_tmci,
   input  logic [NUM_CH-1:0]     i_cascade,
   output logic [NUM_CH-1:0]     o_cnt_en,
   output logic [PRESC_W-1:0]    o_presc
);

   logic [PRESC_W-1:0] presc_q, presc_d;

   // Free-running prescaler with synchronous clear.
   always_comb presc_d = i_presc_clr ? '0 : presc_q + 1'b1;

   // Prescaler register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) presc_q <= '0;
      else          presc_q <= presc_d;
   end

   assign o_presc = presc_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tmr_edge_sel_ch #(
         .PRESC_W  (PRESC_W),
         .SYNC_STG (SYNC_STG),
         .FILT_LEN (FILT_LEN)
      ) u_ch (
         .i_clk       (i_clk),
         .i_rst_n     (i_rst_n),
         .i_presc_clr (i_presc_clr),
         .i_presc     (presc_q),
         .i_cks       (i_cks[3*g +: 3]),
         .i_icks      (i_icks[2*g +: 2]),
         .i_tmci      (i_tmci[g]),
         .i_cascade   (i_cascade[g]),
         .o_cnt_en    (o_cnt_en[g])
      );
   end

endmodule

// File: tb/tb_tmr_cnt_en_gen.sv
// tb_tmr_cnt_en_gen: randomized scoreboard bench for tmr_cnt_en_gen (default build, no TMCI filter)
module tb_tmr_cnt_en_gen;

   localparam int N = 4;
   localparam int PMOD = 8192;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          presc_clr = 1'b0;
   logic [11:0]   cks_v = '0;
   logic [7:0]    icks_v = '0;
   logic [3:0]    tmci_v = '0;
   logic [3:0]    casc_v = '0;
   logic [3:0]    cnt_en;
   logic [12:0]   presc;

   typedef struct packed {
      logic [3:0]  en;
      logic [12:0] presc;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errs = 0;

   int        m_p;
   logic [4:0] m_psel[N];
   logic      m_hist[N];
   logic [3:0] m_t1, m_t2;

   tmr_cnt_en_gen dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_presc_clr (presc_clr),
      .i_cks       (cks_v),
      .i_icks      (icks_v),
      .i_tmci      (tmci_v),
      .i_cascade   (casc_v),
      .o_cnt_en    (cnt_en),
      .o_presc     (presc)
   );

   always #5 clk = ~clk;

   function automatic int tap_div(input logic [2:0] code);
      case (code)
         3'b010:  return 8;
         3'b011:  return 2;
         3'b100:  return 64;
         3'b101:  return 32;
         3'b110:  return 8192;
         3'b111:  return 1024;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_p = 0;
      m_t1 = '0;
      m_t2 = '0;
      for (int n = 0; n < N; n++) begin
         m_psel[n] = '0;
         m_hist[n] = 1'b0;
      end
   endtask

   // Called at a negedge: drive current inputs, predict the outputs after the next posedge, advance to next negedge.
   task automatic cyc();
      exp_t e;
      int   np;
      e.en = '0;
      for (int n = 0; n < N; n++) begin
         logic [2:0] c;
         logic [1:0] ic;
         logic       internal, lvl, r, f, hit;
         int         div;
         c = cks_v[3*n +: 3];
         ic = icks_v[2*n +: 2];
         internal = !c[2];
         div = internal ? tap_div({c[1:0], ic[0]}) : 0;
         lvl = internal ? (div != 0 && ((m_p / (div / 2)) % 2) == 1)
                        : (c[1:0] == 2'b00 ? casc_v[n] : m_t2[n]);
         r = lvl && !m_hist[n];
         f = !lvl && m_hist[n];
         hit = internal ? (div != 0 && (ic[1] ? f : r))
                        : (c[1:0] == 2'b11 ? (r || f) : c[1:0] == 2'b10 ? f : r);
         e.en[n] = ({c, ic} == m_psel[n]) && hit;
         m_hist[n] = (presc_clr && internal) ? 1'b0 : lvl;
         m_psel[n] = {c, ic};
      end
      np = presc_clr ? 0 : (m_p + 1) % PMOD;
      e.presc = 13'(np);
      m_p = np;
      m_t2 = m_t1;
      m_t1 = tmci_v;
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: every cycle the DUT presents o_cnt_en/o_presc; compare against the queued prediction.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (cnt_en !== e.en) begin
               errs++;
               $display("FAIL cnt_en t=%0t got %b exp %b", $time, cnt_en, e.en);
            end
            vectors++;
            if (presc !== e.presc) begin
               errs++;
               $display("FAIL presc t=%0t got %0d exp %0d", $time, presc, e.presc);
            end
         end
      end
   end

   task automatic chk_reset(input string tag);
      vectors++;
      if (cnt_en !== 4'b0 || presc !== 13'd0) begin
         errs++;
         $display("FAIL %s got en=%b presc=%0d exp en=0000 presc=0", tag, cnt_en, presc);
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset("reset_state");
      rst_n = 1'b1;
      // ch0 /2 rising, ch1 /8192 falling, ch2 TMCI both, ch3 cascade
      cks_v = {3'b100, 3'b111, 3'b011, 3'b001};
      icks_v = {2'b00, 2'b00, 2'b10, 2'b01};
      for (int k = 0; k < 9000; k++) begin
         if (k % 10 == 0) tmci_v[2] = ~tmci_v[2];
         tmci_v[0] = 1'($urandom_range(0, 1));
         casc_v[3] = (k < 20) ? (k == 5 || k == 9) : ($urandom_range(0, 5) == 0);
         casc_v[2:0] = 3'($urandom);
         cyc();
      end
      // switch ch0 to /1024 rising, then sprinkle prescaler clears
      cks_v[2:0] = 3'b011;
      icks_v[1:0] = 2'b01;
      for (int k = 0; k < 3000; k++) begin
         presc_clr = (k == 700 || k == 1500 || $urandom_range(0, 400) == 0);
         casc_v = 4'($urandom);
         if ($urandom_range(0, 6) == 0) tmci_v = 4'($urandom);
         cyc();
      end
      presc_clr = 1'b0;
      // fully random selects, levels, cascades and clears
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 63) == 0) begin
            int n;
            n = $urandom_range(0, N - 1);
            cks_v[3*n +: 3] = 3'($urandom);
            icks_v[2*n +: 2] = 2'($urandom);
         end
         presc_clr = ($urandom_range(0, 300) == 0);
         casc_v = 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 3) == 0) tmci_v[$urandom_range(0, N - 1)] ^= 1'b1;
         cyc();
      end
      presc_clr = 1'b0;
      // asynchronous reset mid-run
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("async_reset");
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset_held");
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      cks_v = {3'b111, 3'b010, 3'b100, 3'b001};
      icks_v = {2'b00, 2'b10, 2'b01, 2'b01};
      for (int k = 0; k < 600; k++) begin
         casc_v = 4'($urandom);
         if ($urandom_range(0, 4) == 0) tmci_v = 4'($urandom);
         cyc();
      end
      @(posedge clk);
      #3;
      vectors++;
      if (sb.size() != 0) begin
         errs++;
         $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
